// File: rtl/uart_tx_serial_if.sv
// WR/TBE byte handshake, overwrite-error flag and serial-line status of uart_tx_serial.
// The byte source drives through the master modport; the transmitter uses slave.
interface uart_tx_serial_if;
  logic [7:0] DBIN;
  logic       WR;
  logic       CLR_OE;
  logic       TXD;
  logic       TBE;
  logic       BUSY;
  logic       OE;

  modport master (
    output DBIN,
    output WR,
    output CLR_OE,
    input  TXD,
    input  TBE,
    input  BUSY,
    input  OE
  );

  modport slave (
    input  DBIN,
    input  WR,
    input  CLR_OE,
    output TXD,
    output TBE,
    output BUSY,
    output OE
  );
endinterface

// File: rtl/uart_tx_serial.sv
// UART transmitter: one-byte holding register, LSB-first framing with 1 or 2 stop bits.
// Define UART_TX_PARITY_EN to insert an odd-parity bit after data bit 7 (8-O-1 framing).
module uart_tx_serial #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int BAUD      = 9600,
  parameter int STOP_BITS = 1
) (
  input  logic             clk,
  input  logic             RST_n,
  uart_tx_serial_if.slave  bus
);

  localparam int              DIVISOR   = CLK_FREQ / BAUD;
  localparam int              CNT_W     = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DIVISOR - 1);
  localparam logic            STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction
`else
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd4
  } state_e;
`endif

  state_e           state_q,     state_d;
  logic [CNT_W-1:0] cnt_q,       cnt_d;
  logic [7:0]       hold_q,      hold_d;
  logic             hold_full_q, hold_full_d;
  logic [7:0]       shift_q,     shift_d;
  logic [2:0]       bit_idx_q,   bit_idx_d;
  logic             stop_idx_q,  stop_idx_d;
  logic             txd_q,       txd_d;
  logic             busy_q,      busy_d;
  logic             oe_q,        oe_d;
`ifdef UART_TX_PARITY_EN
  logic             parity_q,    parity_d;
`endif

  logic             bit_end_s;
  logic             load_s;

  assign bit_end_s = (cnt_q == CNT_MAX);

  // Next-state, line and handshake logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
    stop_idx_d  = stop_idx_q;
    txd_d       = txd_q;
    busy_d      = busy_q;
    oe_d        = oe_q;
`ifdef UART_TX_PARITY_EN
    parity_d    = parity_q;
`endif
    load_s      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (hold_full_q) begin
          load_s = 1'b1;
        end else begin
          txd_d  = 1'b1;
          busy_d = 1'b0;
          cnt_d  = '0;
        end
      end
      S_START: begin
        if (bit_end_s) begin
          state_d   = S_DATA;
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          txd_d     = shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (bit_end_s) begin
          cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
            txd_d   = parity_q;
`else
            state_d    = S_STOP;
            stop_idx_d = 1'b0;
            txd_d      = 1'b1;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            txd_d     = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end_s) begin
          state_d    = S_STOP;
          stop_idx_d = 1'b0;
          txd_d      = 1'b1;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (bit_end_s) begin
          cnt_d = '0;
          if (stop_idx_q == STOP_LAST) begin
            // A queued byte starts its frame with no idle gap
            if (hold_full_q) begin
              load_s = 1'b1;
            end else begin
              state_d = S_IDLE;
              busy_d  = 1'b0;
              txd_d   = 1'b1;
            end
          end else begin
            stop_idx_d = stop_idx_q + 1'b1;
            txd_d      = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        txd_d   = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    if (load_s) begin
      state_d     = S_START;
      cnt_d       = '0;
      shift_d     = hold_q;
      hold_full_d = 1'b0;
      txd_d       = 1'b0;
      busy_d      = 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_d    = odd_parity(hold_q);
`endif
    end else begin
      hold_full_d = hold_full_d;
    end

    // load_s needs hold_full_q, so it never coincides with an accepted write
    if (bus.WR && !hold_full_q) begin
      hold_d      = bus.DBIN;
      hold_full_d = 1'b1;
    end else begin
      hold_d = hold_d;
    end

    // Set has priority over clear
    if (bus.WR && hold_full_q) begin
      oe_d = 1'b1;
    end else if (bus.CLR_OE) begin
      oe_d = 1'b0;
    end else begin
      oe_d = oe_q;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      shift_q     <= 8'h00;
      bit_idx_q   <= 3'd0;
      stop_idx_q  <= 1'b0;
      txd_q       <= 1'b1;
      busy_q      <= 1'b0;
      oe_q        <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      stop_idx_q  <= stop_idx_d;
      txd_q       <= txd_d;
      busy_q      <= busy_d;
      oe_q        <= oe_d;
`ifdef UART_TX_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

  assign bus.TXD  = txd_q;
  assign bus.TBE  = ~hold_full_q;
  assign bus.BUSY = busy_q;
  assign bus.OE   = oe_q;

endmodule
